multicycle_adder: RTL and testbench

- Sequential adder that computes DataA + DataB + CarryIn over several cycles, one SliceBits-wide slice per cycle, starting at the LSB slice.
- The carry ripples through a registered carry flop.
- It is the adder counterpart to the team's combinational borrow-chain subtractor. It serves the datapath where a full-width single-cycle carry chain misses timing.
- Result, CarryOut and Overflow are held stable between operations.

---
 rtl/adder_pkg.sv | 15 +
 rtl/slice_adder.sv | 22 ++
 rtl/multicycle_adder.sv | 126 ++++++++++++
 tb/tb_multicycle_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types for the multicycle adder.
// Provides the FSM state enum and the slice-count helper.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int nr_of_slices(input int nbits, input int sbits);
      return nbits / sbits;
   endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational SliceBits-wide adder for one slice of the multicycle adder.
// Ports: a, b, cin in; sum, cout, msb_cin (carry into the slice top bit) out.
module slice_adder #(
   parameter int SliceBits = 8
) (
   input  logic [SliceBits-1:0] a,
   input  logic [SliceBits-1:0] b,
   input  logic                 cin,
   output logic [SliceBits-1:0] sum,
   output logic                 cout,
   output logic                 msb_cin
);

   logic [SliceBits:0] w_full;

   assign w_full  = {1'b0, a} + {1'b0, b} + {{SliceBits{1'b0}}, cin};
   assign sum     = w_full[SliceBits-1:0];
   assign cout    = w_full[SliceBits];
   // Top sum bit is a^b^carry_in, so the carry into it falls out directly
   assign msb_cin = a[SliceBits-1] ^ b[SliceBits-1] ^ sum[SliceBits-1];

endmodule

// File: rtl/multicycle_adder.sv
// Sequential adder: DataA + DataB + CarryIn, one SliceBits slice per cycle.
// Ports: clock, reset_n, Start, CarryIn, DataA, DataB in; Busy, Done, Result, CarryOut, Overflow out.
module multicycle_adder
   import adder_pkg::*;
#(
   parameter int NrOfBits  = 32,
   parameter int SliceBits = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                Start,
   input  logic                CarryIn,
   input  logic [NrOfBits-1:0] DataA,
   input  logic [NrOfBits-1:0] DataB,
   output logic                Busy,
   output logic                Done,
   output logic [NrOfBits-1:0] Result,
   output logic                CarryOut,
   output logic                Overflow
);

   localparam int NrOfSlices = nr_of_slices(NrOfBits, SliceBits);
   localparam int CntW       = (NrOfSlices > 1) ? $clog2(NrOfSlices) : 1;

   if ((NrOfBits % SliceBits) != 0) begin : g_bad_slice
      $error("SliceBits must divide NrOfBits");
   end

   state_t              r_state;
   logic [CntW-1:0]     r_cnt;
   logic [NrOfBits-1:0] r_a;
   logic [NrOfBits-1:0] r_b;
   logic                r_carry;
   logic [NrOfBits-1:0] r_psum;
   logic [NrOfBits-1:0] r_result;
   logic                r_cout;
   logic                r_ovf;
   logic                r_busy;
   logic                r_done;

   logic [SliceBits-1:0] w_a_sl;
   logic [SliceBits-1:0] w_b_sl;
   logic [SliceBits-1:0] w_sum;
   logic                 w_cout;
   logic                 w_msb_cin;
   logic [NrOfBits-1:0]  w_psum_nxt;
   logic                 w_last;

   always_comb begin
      w_a_sl     = r_a[int'(r_cnt)*SliceBits +: SliceBits];
      w_b_sl     = r_b[int'(r_cnt)*SliceBits +: SliceBits];
      w_psum_nxt = r_psum;
      w_psum_nxt[int'(r_cnt)*SliceBits +: SliceBits] = w_sum;
   end

   assign w_last = (r_cnt == CntW'(NrOfSlices - 1));

   slice_adder #(
      .SliceBits (SliceBits)
   ) u_slice (
      .a       (w_a_sl),
      .b       (w_b_sl),
      .cin     (r_carry),
      .sum     (w_sum),
      .cout    (w_cout),
      .msb_cin (w_msb_cin)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_psum   <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE, DONE: begin
               // DONE accepts Start too, giving back-to-back operation
               if (Start) begin
                  r_a     <= DataA;
                  r_b     <= DataB;
                  r_carry <= CarryIn;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_psum  <= w_psum_nxt;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result <= w_psum_nxt;
                  r_cout   <= w_cout;
                  r_ovf    <= w_msb_cin ^ w_cout;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign Busy     = r_busy;
   assign Done     = r_done;
   assign Result   = r_result;
   assign CarryOut = r_cout;
   assign Overflow = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed self-checking bench for multicycle_adder (32 bits, 8-bit slices).
// Vectors and expected sums are hand-computed constants.
module tb_multicycle_adder;

   logic        clock;
   logic        reset_n;
   logic        Start;
   logic        CarryIn;
   logic [31:0] DataA;
   logic [31:0] DataB;
   logic        Busy;
   logic        Done;
   logic [31:0] Result;
   logic        CarryOut;
   logic        Overflow;

   int n_cmp;
   int n_err;

   multicycle_adder #(
      .NrOfBits  (32),
      .SliceBits (8)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .Start    (Start),
      .CarryIn  (CarryIn),
      .DataA    (DataA),
      .DataB    (DataB),
      .Busy     (Busy),
      .Done     (Done),
      .Result   (Result),
      .CarryOut (CarryOut),
      .Overflow (Overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse Start with the operands, wait for Done, check latency and outputs
   task automatic run_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic cin,
                         input logic [31:0] er, input logic ec,
                         input logic ev);
      int nb;
      logic seen;
      nb = 0;
      seen = 1'b0;
      @(negedge clock);
      DataA = a;
      DataB = b;
      CarryIn = cin;
      Start = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (k == 0) Start = 1'b0;
         if (Done) begin
            seen = 1'b1;
            break;
         end
         if (Busy) nb++;
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_busy_cycles"}, nb, 32'd4);
      chk({tag, "_result"}, Result, er);
      chk({tag, "_cout"}, 32'(CarryOut), 32'(ec));
      chk({tag, "_ovf"}, 32'(Overflow), 32'(ev));
      @(negedge clock);
      chk({tag, "_done_1cyc"}, 32'(Done), 32'd0);
      chk({tag, "_held"}, Result, er);
   endtask

   initial begin
      int nb;
      int cyc;
      int d1;
      int d2;
      logic seen;
      logic [31:0] r1;
      n_cmp = 0;
      n_err = 0;
      reset_n = 1'b0;
      Start = 1'b0;
      CarryIn = 1'b0;
      DataA = '0;
      DataB = '0;

      // Reset held for 3 cycles
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_result", Result, 32'd0);
      chk("rst_flags", {30'd0, CarryOut, Overflow}, 32'd0);
      reset_n = 1'b1;

      // Idle: no Done without Start
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (Done || Busy) seen = 1'b1;
      end
      chk("idle_quiet", 32'(seen), 32'd0);

      run_op("basic", 32'h0000_00FF, 32'h0000_0001, 1'b0,
             32'h0000_0100, 1'b0, 1'b0);
      run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1,
             32'h0000_0000, 1'b1, 1'b0);
      run_op("sovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);
      run_op("sovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0,
             32'h0000_0000, 1'b1, 1'b1);

      // Start pulsed in RUN with other operands must be ignored
      @(negedge clock);
      DataA = 32'h0000_00FF;
      DataB = 32'h0000_0001;
      CarryIn = 1'b0;
      Start = 1'b1;
      nb = 0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (k == 0) Start = 1'b0;
         if (k == 1) begin
            DataA = 32'hAAAA_AAAA;
            DataB = 32'h5555_5555;
            CarryIn = 1'b1;
            Start = 1'b1;
         end
         if (k == 2) Start = 1'b0;
         if (Done) begin
            seen = 1'b1;
            break;
         end
         if (Busy) nb++;
      end
      chk("ign_done_seen", 32'(seen), 32'd1);
      chk("ign_busy_cycles", nb, 32'd4);
      chk("ign_result", Result, 32'h0000_0100);
      chk("ign_flags", {30'd0, CarryOut, Overflow}, 32'd0);
      @(negedge clock);
      chk("ign_no_restart", 32'(Busy), 32'd0);

      // Start held high through DONE: back-to-back
      @(negedge clock);
      DataA = 32'h0000_0010;
      DataB = 32'h0000_0020;
      CarryIn = 1'b0;
      Start = 1'b1;
      d1 = -1;
      d2 = -1;
      r1 = '0;
      for (cyc = 0; cyc < 30; cyc++) begin
         @(negedge clock);
         if (cyc == 0) begin
            DataA = 32'h0F0F_0F0F;
            DataB = 32'h0101_0101;
         end
         if (Done) begin
            if (d1 < 0) begin
               d1 = cyc;
               r1 = Result;
            end else begin
               d2 = cyc;
               Start = 1'b0;
               break;
            end
         end
      end
      chk("b2b_both_done", 32'((d1 >= 0) && (d2 >= 0)), 32'd1);
      chk("b2b_first", r1, 32'h0000_0030);
      chk("b2b_second", Result, 32'h1010_1010);
      chk("b2b_spacing", d2 - d1, 32'd5);

      // Reset in the 2nd RUN cycle aborts the operation
      @(negedge clock);
      DataA = 32'hFFFF_0000;
      DataB = 32'h0000_FFFF;
      Start = 1'b1;
      @(negedge clock);
      Start = 1'b0;
      @(negedge clock);
      chk("abort_busy_before", 32'(Busy), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_outs", {Busy, Done, CarryOut, Overflow}, 32'd0);
      chk("abort_result", Result, 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         if (k == 2) reset_n = 1'b1;
         if (Done || Busy) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);

      run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0,
             32'h2345_6789, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
